// File: rtl/vec_pack.sv
// vec_pack: gathers one float per beat into a zero-padded VEC_SIZE-wide packed vector.
// Latency: m_valid rises one cycle after the closing beat is accepted while the output is free.
// Backpressure: s_ready = !pend; filling continues while the output is full, only a blocked close stalls.
// Optional: define VEC_PACK_NAN_FLAG_EN to add m_has_nan (any real element is a NaN).
module vec_pack #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int BIAS      = -127,
  parameter int VEC_SIZE  = 17,
  localparam int FW = 1 + EXP_WIDTH + MAN_WIDTH,
  localparam int LW = $clog2(VEC_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [FW-1:0]          s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [VEC_SIZE*FW-1:0] m_data,
  output logic [LW-1:0]          m_len
`ifdef VEC_PACK_NAN_FLAG_EN
  ,
  output logic                   m_has_nan
`endif
);

  // The exponent bias must be representable in the exponent field; a
  // one-element vector is not a vector.
  if (VEC_SIZE < 2 || -BIAS >= (1 << EXP_WIDTH)) begin : g_bad_cfg
    $error("vec_pack: unsupported parameter combination");
  end

  // Fill buffer: slot VEC_SIZE-1 is never stored, the last element always
  // closes the vector and goes straight to the output (or the pend capture).
  logic [FW-1:0]          slots_q [VEC_SIZE-1];
  logic [FW-1:0]          slots_d [VEC_SIZE-1];
  logic [LW-1:0]          cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [FW-1:0]          pend_elem_q, pend_elem_d;
  logic                   m_valid_q, m_valid_d;
  logic [VEC_SIZE*FW-1:0] m_data_q, m_data_d;
  logic [LW-1:0]          m_len_q, m_len_d;

  logic                   accept;
  logic                   closing;
  logic                   out_free;
  logic                   load;
  logic [FW-1:0]          asm_elem;
  logic [VEC_SIZE*FW-1:0] asm_vec;
  logic [LW-1:0]          asm_len;

`ifdef VEC_PACK_NAN_FLAG_EN
  logic                   nan_acc_q, nan_acc_d;
  logic                   m_has_nan_q, m_has_nan_d;
  logic                   elem_nan;
`endif

  // Handshake decode shared by the fill and output paths.
  always_comb begin
    accept   = s_valid && !pend_q;
    closing  = s_last || (cnt_q == LW'(VEC_SIZE - 1));
    out_free = !m_valid_q || m_ready;
    load     = pend_q ? out_free : (accept && closing && out_free);
  end

  // Assemble the outgoing vector: stored slots below cnt, the closing element
  // at cnt (captured copy while pending), zeros above.
  always_comb begin
    asm_elem = pend_q ? pend_elem_q : s_data;
    asm_vec  = '0;
    for (int i = 0; i < VEC_SIZE - 1; i++) begin
      if (LW'(i) < cnt_q) asm_vec[i*FW +: FW] = slots_q[i];
    end
    for (int i = 0; i < VEC_SIZE; i++) begin
      if (LW'(i) == cnt_q) asm_vec[i*FW +: FW] = asm_elem;
    end
    asm_len = cnt_q + LW'(1);
  end

  // Next-state for fill buffer, pend capture and output register.
  always_comb begin
    slots_d     = slots_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_elem_d = pend_elem_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_len_d     = m_len_q;

    if (pend_q) begin
      if (out_free) begin
        pend_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (accept) begin
      if (closing) begin
        if (out_free) begin
          cnt_d = '0;
        end else begin
          pend_d      = 1'b1;
          pend_elem_d = s_data;
        end
      end else begin
        for (int i = 0; i < VEC_SIZE - 1; i++) begin
          if (cnt_q == LW'(i)) slots_d[i] = s_data;
        end
        cnt_d = cnt_q + LW'(1);
      end
    end

    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = asm_vec;
      m_len_d   = asm_len;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partial vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_SIZE - 1; i++) slots_q[i] <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_elem_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_len_q     <= '0;
    end else begin
      slots_q     <= slots_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_elem_q <= pend_elem_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_len_q     <= m_len_d;
    end
  end

  assign s_ready = !pend_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_len   = m_len_q;

`ifdef VEC_PACK_NAN_FLAG_EN
  // Sticky NaN accumulation; a pending close has already folded its element in.
  always_comb begin
    elem_nan    = (&s_data[FW-2 -: EXP_WIDTH]) && (|s_data[MAN_WIDTH-1:0]);
    nan_acc_d   = nan_acc_q;
    m_has_nan_d = m_has_nan_q;
    if (load) begin
      nan_acc_d   = 1'b0;
      m_has_nan_d = pend_q ? nan_acc_q : (nan_acc_q | elem_nan);
    end else if (accept) begin
      nan_acc_d = nan_acc_q | elem_nan;
    end
  end

  // NaN flag registers, loaded alongside m_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_acc_q   <= 1'b0;
      m_has_nan_q <= 1'b0;
    end else begin
      nan_acc_q   <= nan_acc_d;
      m_has_nan_q <= m_has_nan_d;
    end
  end

  assign m_has_nan = m_has_nan_q;
`endif

endmodule

// File: tb/tb_vec_pack.sv
// Directed bench for vec_pack at default parameters (FW=32, VEC_SIZE=17).
// Inputs change 1ns after the rising edge; outputs are checked at that point.
// Each scenario task performs its own comparisons.
module tb_vec_pack;
  localparam int VS = 17;
  localparam int FW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [FW-1:0]     s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [VS*FW-1:0]  m_data;
  logic [4:0]        m_len;
`ifdef VEC_PACK_NAN_FLAG_EN
  logic              m_has_nan;
`endif

  int checks   = 0;
  int failures = 0;
  logic [VS*FW-1:0] exp_v;
  logic [VS*FW-1:0] a_v;

  vec_pack dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_len   (m_len)
`ifdef VEC_PACK_NAN_FLAG_EN
    ,
    .m_has_nan (m_has_nan)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [FW-1:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    checks++; if (m_len !== 5'd0) begin failures++; $display("FAIL reset_m_len got=%0d exp=0", m_len); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
`ifdef VEC_PACK_NAN_FLAG_EN
    checks++; if (m_has_nan !== 1'b0) begin failures++; $display("FAIL reset_m_has_nan got=%0b exp=0", m_has_nan); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full();
    m_ready = 1'b1;
    for (int i = 0; i < VS; i++) begin
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL full_s_ready beat=%0d got=%0b exp=1", i, s_ready); end
      if (i == VS - 1) begin
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid got=%0b exp=0", m_valid); end
      end
      beat(32'h3F80_0000 + i, 1'b0);
    end
    for (int i = 0; i < VS; i++) exp_v[i*FW +: FW] = 32'h3F80_0000 + i;
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL full_m_valid got=%0b exp=1", m_valid); end
    checks++; if (m_len !== 5'd17) begin failures++; $display("FAIL full_m_len got=%0d exp=17", m_len); end
    checks++; if (m_data !== exp_v) begin failures++; $display("FAIL full_m_data got=%h exp=%h", m_data, exp_v); end
    step();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%0b exp=0", m_valid); end
  endtask

  task automatic test_short();
    m_ready = 1'b1;
    beat(32'h4000_0000, 1'b0);
    beat(32'h4040_0000, 1'b0);
    beat(32'h4080_0000, 1'b1);
    exp_v = '0;
    exp_v[0*FW +: FW] = 32'h4000_0000;
    exp_v[1*FW +: FW] = 32'h4040_0000;
    exp_v[2*FW +: FW] = 32'h4080_0000;
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL short_m_valid got=%0b exp=1", m_valid); end
    checks++; if (m_len !== 5'd3) begin failures++; $display("FAIL short_m_len got=%0d exp=3", m_len); end
    checks++; if (m_data !== exp_v) begin failures++; $display("FAIL short_m_data got=%h exp=%h", m_data, exp_v); end
    step();
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    for (int i = 0; i < VS; i++) beat(32'h100 + i, 1'b0);
    for (int i = 0; i < VS; i++) a_v[i*FW +: FW] = 32'h100 + i;
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_a_valid got=%0b exp=1", m_valid); end
    for (int i = 0; i < VS; i++) begin
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_b_s_ready beat=%0d got=%0b exp=1", i, s_ready); end
      beat(32'h200 + i, 1'b0);
    end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_pend_s_ready got=%0b exp=0", s_ready); end
    checks++; if (m_data !== a_v) begin failures++; $display("FAIL bp_a_held got=%h exp=%h", m_data, a_v); end
    repeat (2) step();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_pend_hold got=%0b exp=0", s_ready); end
    checks++; if (m_data !== a_v) begin failures++; $display("FAIL bp_a_stable got=%h exp=%h", m_data, a_v); end
    m_ready = 1'b1;
    step();
    for (int i = 0; i < VS; i++) exp_v[i*FW +: FW] = 32'h200 + i;
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_b_valid got=%0b exp=1", m_valid); end
    checks++; if (m_data !== exp_v) begin failures++; $display("FAIL bp_b_data got=%h exp=%h", m_data, exp_v); end
    checks++; if (m_len !== 5'd17) begin failures++; $display("FAIL bp_b_len got=%0d exp=17", m_len); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_s_ready_back got=%0b exp=1", s_ready); end
    step();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_b_drained got=%0b exp=0", m_valid); end
  endtask

  task automatic test_drain_close();
    m_ready = 1'b0;
    beat(32'hA1, 1'b0);
    beat(32'hA2, 1'b1);
    checks++; if (m_len !== 5'd2) begin failures++; $display("FAIL dc_a_len got=%0d exp=2", m_len); end
    beat(32'hC1, 1'b0);
    s_valid = 1'b1; s_data = 32'hC2; s_last = 1'b1; m_ready = 1'b1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL dc_close_s_ready got=%0b exp=1", s_ready); end
    step();
    s_valid = 1'b0; s_last = 1'b0;
    exp_v = '0;
    exp_v[0*FW +: FW] = 32'hC1;
    exp_v[1*FW +: FW] = 32'hC2;
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL dc_c_valid got=%0b exp=1", m_valid); end
    checks++; if (m_data !== exp_v) begin failures++; $display("FAIL dc_c_data got=%h exp=%h", m_data, exp_v); end
    checks++; if (m_len !== 5'd2) begin failures++; $display("FAIL dc_c_len got=%0d exp=2", m_len); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL dc_no_bubble got=%0b exp=1", s_ready); end
    step();
  endtask

  task automatic test_reset_midfill();
    m_ready = 1'b0;
    beat(32'h55, 1'b1);
    for (int i = 0; i < 5; i++) beat(32'hDEAD_0000 + i, 1'b0);
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%0b exp=1", m_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rm_m_valid got=%0b exp=0", m_valid); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL rm_m_data got=%h exp=0", m_data); end
    checks++; if (m_len !== 5'd0) begin failures++; $display("FAIL rm_m_len got=%0d exp=0", m_len); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rm_s_ready got=%0b exp=1", s_ready); end
    #2 rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    for (int i = 0; i < VS; i++) beat(32'h1, 1'b0);
    for (int i = 0; i < VS; i++) exp_v[i*FW +: FW] = 32'h1;
    checks++; if (m_len !== 5'd17) begin failures++; $display("FAIL rm_after_len got=%0d exp=17", m_len); end
    checks++; if (m_data !== exp_v) begin failures++; $display("FAIL rm_after_data got=%h exp=%h", m_data, exp_v); end
    step();
  endtask

  task automatic test_nan();
    m_ready = 1'b1;
    beat(32'h7FC0_0000, 1'b0);
    beat(32'hFF80_0000, 1'b0);
    beat(32'h8000_0000, 1'b1);
    exp_v = '0;
    exp_v[0*FW +: FW] = 32'h7FC0_0000;
    exp_v[1*FW +: FW] = 32'hFF80_0000;
    exp_v[2*FW +: FW] = 32'h8000_0000;
    checks++; if (m_data !== exp_v) begin failures++; $display("FAIL nan_data got=%h exp=%h", m_data, exp_v); end
    checks++; if (m_len !== 5'd3) begin failures++; $display("FAIL nan_len got=%0d exp=3", m_len); end
`ifdef VEC_PACK_NAN_FLAG_EN
    checks++; if (m_has_nan !== 1'b1) begin failures++; $display("FAIL nan_flag_set got=%0b exp=1", m_has_nan); end
`endif
    step();
    beat(32'h7F80_0000, 1'b1);
    exp_v = '0;
    exp_v[0*FW +: FW] = 32'h7F80_0000;
    checks++; if (m_data !== exp_v) begin failures++; $display("FAIL inf_data got=%h exp=%h", m_data, exp_v); end
    checks++; if (m_len !== 5'd1) begin failures++; $display("FAIL inf_len got=%0d exp=1", m_len); end
`ifdef VEC_PACK_NAN_FLAG_EN
    checks++; if (m_has_nan !== 1'b0) begin failures++; $display("FAIL nan_flag_clear got=%0b exp=0", m_has_nan); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_full();
    test_short();
    test_backpressure();
    test_drain_close();
    test_reset_midfill();
    test_nan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
